// File: rtl/mod_updown_counter_pkg.sv
// Shared encodings for the up/down counter family.
package mod_updown_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DN    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/n_bit_reg.sv
// Generic W-bit register with asynchronous active-high reset to zero.
module n_bit_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/step_addsub.sv
// Adds or subtracts a 0..2 step in WIDTH+1 bits and flags crossing 0 or MAX.
module step_addsub #(
    parameter int WIDTH = 10,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [1:0]       step_i,
    input  logic             sub_i,
    output logic [WIDTH:0]   res_o,
    output logic             lim_o
);

    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX);

    logic [WIDTH:0] a_w;
    logic [WIDTH:0] step_w;

    assign a_w    = {1'b0, a_i};
    assign step_w = (WIDTH+1)'(step_i);

    // Down results wrap modulo 2**(WIDTH+1); the caller folds them back with MAX+1.
    assign res_o = sub_i ? (a_w - step_w) : (a_w + step_w);
    assign lim_o = sub_i ? (a_w < step_w) : ((a_w + step_w) > MAX_W);

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo MAX+1 up/down counter with dual step enables, load, wrap/saturate modes.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en1,
    input  logic             en2,
    input  logic             dir,
    input  logic             sat,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] count,
    output logic             co,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH:0]   MODULUS = (WIDTH+1)'(MAX+1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [0:0]       co_q, co_d;
    logic [1:0]       step;
    logic [WIDTH:0]   res;
    logic             lim;

    assign step = {1'b0, en1} + {1'b0, en2};

    step_addsub #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_addsub (
        .a_i    (count_q),
        .step_i (step),
        .sub_i  (dir == DIR_DN),
        .res_o  (res),
        .lim_o  (lim)
    );

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch behind.
        count_d = count_q;
        co_d    = 1'b0;
        if (ld) begin
            count_d = (ld_val > MAX_V) ? MAX_V : ld_val;
        end else if (!lim) begin
            count_d = res[WIDTH-1:0];
        end else begin
            co_d = 1'b1;
            if (sat == MODE_SAT) begin
                count_d = (dir == DIR_UP) ? MAX_V : '0;
            end else begin
                count_d = (dir == DIR_UP) ? WIDTH'(res - MODULUS) : WIDTH'(res + MODULUS);
            end
        end
    end

    n_bit_reg #(.W(WIDTH)) u_count_reg (
        .clk (clk),
        .rst (rst),
        .d_i (count_d),
        .q_o (count_q)
    );

    n_bit_reg #(.W(1)) u_co_reg (
        .clk (clk),
        .rst (rst),
        .d_i (co_d),
        .q_o (co_q)
    );

    assign count  = count_q;
    assign co     = co_q[0];
    assign at_max = (count_q == MAX_V);
    assign at_min = (count_q == '0);

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 10, count register width in bits (WIDTH >= 2).
REQ-002 Parameter MAX, default 2**WIDTH-1, terminal count value; the counter SHALL be modulo MAX+1 (MAX <= 2**WIDTH-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en1  input  1  step enable A, contributes 1 to step.
REQ-006 en2  input  1  step enable B, contributes 1 to step; step = en1 + en2 (0, 1 or 2).
REQ-007 dir  input  1  direction: 0 up, 1 down.
REQ-008 sat  input  1  mode: 0 wrap, 1 saturate.
REQ-009 ld  input  1  synchronous load strobe.
REQ-010 ld_val  input  WIDTH  load value.
REQ-011 count  output  WIDTH  registered count.
REQ-012 co  output  1  registered one-cycle event pulse (wrap or saturation).
REQ-013 at_max  output  1  combinational, count == MAX.
REQ-014 at_min  output  1  combinational, count == 0.

Function
REQ-015 Priority per edge SHALL be ld > step; ld with en1/en2 active SHALL load only, co=0 next cycle.
REQ-016 Load SHALL store min(ld_val, MAX); ld_val > MAX clamps to MAX, no co.
REQ-017 step = 0 and ld = 0: count SHALL hold, co SHALL be 0 next cycle.
REQ-018 Up, no overflow (count+step <= MAX): count <= count+step, co <= 0.
REQ-019 Up, overflow, wrap mode: count <= count+step-(MAX+1), co <= 1 for one cycle.
REQ-020 Up, overflow, saturate mode: count <= MAX, co <= 1 for one cycle.
REQ-021 Down, no underflow (count >= step): count <= count-step, co <= 0.
REQ-022 Down, underflow, wrap mode: count <= count+(MAX+1)-step, co <= 1.
REQ-023 Down, underflow, saturate mode: count <= 0, co <= 1.
REQ-024 Saturate mode holding at limit with step in limit direction SHALL re-assert co every such cycle.
REQ-025 Intermediate arithmetic SHALL be WIDTH+1 bits wide; no truncation before the modulo or clamp decision.
REQ-026 dir and sat SHALL be sampled each cycle; changing them mid-count SHALL take effect on the same edge with no extra latency.
REQ-027 Latency: count and co SHALL reflect inputs one clock after the sampling edge; at_max and at_min SHALL follow count combinationally.

Reset
REQ-028 rst=1 SHALL immediately force count=0 and co=0, independent of clk; at_min=1, at_max=(MAX==0 ? 1 : 0).
REQ-029 Reset mid-operation SHALL discard any pending load or step; the first edge after deassertion SHALL operate normally.

Structure
REQ-030 Mode and direction encodings (DIR_UP, DIR_DN, MODE_WRAP, MODE_SAT) SHALL be constants in the shared counter package/header.
REQ-031 One sub-module, step_addsub (WIDTH+1-bit add/subtract of 0..2, with overflow/underflow flag), SHALL compute the next value; the state register SHALL reuse the codebase's n_bit_reg.

Verification (WIDTH=4, MAX=9)
REQ-032 rst pulse mid-count at count=5 -> count=0, co=0 asynchronously, before the next edge.
REQ-033 Wrap, up, en1 only, from 8 -> 9, then 0 with co=1 for exactly one cycle, then 1 with co=0.
REQ-034 Wrap, up, en1=en2=1 from 8 -> 0 (8+2-10) with co=1; down, both enables, from 1 -> 9 with co=1.
REQ-035 Saturate, up, en1 from 9 for 3 cycles -> count stays 9, co=1 each cycle; dir=1 same edge -> 8, co=0.
REQ-036 ld=1, ld_val=13, en1=1 -> count=9 (clamped), co=0, at_max=1; ld_val=3 -> count=3.
REQ-037 Random en1/en2/dir/sat/ld for 10k cycles vs reference model -> count and co match every cycle.
